// File: rtl/systolic_seq_if.sv
// Bundle between the systolic sequencer, the io register block and the operand buffer RAM.
// The master side is the io/buffer side; the slave side is the sequencer.
interface systolic_seq_if #(
  parameter int DW = 16,
  parameter int LW = 8
);
  logic            cfg_go;
  logic            cfg_abort;
  logic [LW-1:0]   cfg_len;
  logic            busy;
  logic            done;
  logic            err_len;
  logic            aborted;
  logic            buf_ren;
  logic [LW-1:0]   buf_radr;
  logic [4*DW-1:0] buf_a_rdata;
  logic [4*DW-1:0] buf_b_rdata;

  modport master (
    output cfg_go, cfg_abort, cfg_len, buf_a_rdata, buf_b_rdata,
    input  busy, done, err_len, aborted, buf_ren, buf_radr
  );

  modport slave (
    input  cfg_go, cfg_abort, cfg_len, buf_a_rdata, buf_b_rdata,
    output busy, done, err_len, aborted, buf_ren, buf_radr
  );
endinterface

// File: rtl/systolic_seq.sv
// Sequencer for the 4x4 systolic PE array: reads K operand columns/rows from the
// buffer and feeds them into the array edges with a per-lane diagonal skew.
module systolic_seq #(
  parameter int DW        = 16,
  parameter int LW        = 8,
  parameter int DRAIN_CYC = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  systolic_seq_if.slave bus,
  output logic          start,
  output logic [LW-1:0] max_cntr,
  output logic [DW-1:0] a_in0, a_in1, a_in2, a_in3,
  output logic [DW-1:0] b_in0, b_in1, b_in2, b_in3,
  output logic          awe0, awe1, awe2, awe3,
  output logic          bwe0, bwe1, bwe2, bwe3
);

  // One extra bit so FEED can count up to len+3 without wrapping at len=255.
  localparam int CW = LW + 1;

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [3:0]    vld_q;
  logic [DW-1:0] a_d1 [1:3], b_d1 [1:3];
  logic [DW-1:0] a_d2 [2:3], b_d2 [2:3];
  logic [DW-1:0] a_d3, b_d3;

  logic go_ok, go_bad, abort_hit, feed_last, drain_last, rd_active;

  assign go_ok      = (state_q == S_IDLE) && bus.cfg_go && (bus.cfg_len != '0);
  assign go_bad     = (state_q == S_IDLE) && bus.cfg_go && (bus.cfg_len == '0);
  assign abort_hit  = (state_q != S_IDLE) && bus.cfg_abort;
  assign feed_last  = cnt_q == ({1'b0, max_cntr} + CW'(3));
  assign drain_last = cnt_q == CW'(DRAIN_CYC - 1);
  assign rd_active  = (state_q == S_FEED) && (cnt_q < {1'b0, max_cntr});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    state_d = state_q;
    if (abort_hit) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (go_ok) state_d = S_CLR;
        S_CLR:   state_d = S_FEED;
        S_FEED:  if (feed_last) state_d = S_DRAIN;
        S_DRAIN: if (drain_last) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy     = state_q != S_IDLE;
    bus.done     = state_q == S_DONE;
    start        = state_q == S_CLR;
    bus.buf_ren  = rd_active;
    bus.buf_radr = rd_active ? cnt_q[LW-1:0] : '0;
  end

  // Phase counter restarts on every state change; only FEED and DRAIN use it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      max_cntr    <= '0;
      bus.err_len <= 1'b0;
      bus.aborted <= 1'b0;
    end else begin
      if (state_d != state_q)                            cnt_q <= '0;
      else if (state_q == S_FEED || state_q == S_DRAIN)  cnt_q <= cnt_q + 1'b1;

      if (go_ok) begin
        max_cntr    <= bus.cfg_len;
        bus.err_len <= 1'b0;
        bus.aborted <= 1'b0;
      end else if (go_bad) begin
        bus.err_len <= 1'b1;
      end
      if (abort_hit) bus.aborted <= 1'b1;
    end
  end

  // Skew pipeline: lane i passes through i registers after the RAM read stage.
  // NOTE: the skew registers are reset and flushed explicitly so an abort or
  // reset never leaves stale operands behind a later strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 1; i <= 3; i++) begin a_d1[i] <= '0; b_d1[i] <= '0; end
      for (int i = 2; i <= 3; i++) begin a_d2[i] <= '0; b_d2[i] <= '0; end
      a_d3 <= '0;
      b_d3 <= '0;
    end else if (abort_hit) begin
      vld_q <= '0;
      for (int i = 1; i <= 3; i++) begin a_d1[i] <= '0; b_d1[i] <= '0; end
      for (int i = 2; i <= 3; i++) begin a_d2[i] <= '0; b_d2[i] <= '0; end
      a_d3 <= '0;
      b_d3 <= '0;
    end else begin
      vld_q <= {vld_q[2:0], rd_active};
      for (int i = 1; i <= 3; i++) begin
        a_d1[i] <= bus.buf_a_rdata[i*DW +: DW];
        b_d1[i] <= bus.buf_b_rdata[i*DW +: DW];
      end
      for (int i = 2; i <= 3; i++) begin
        a_d2[i] <= a_d1[i];
        b_d2[i] <= b_d1[i];
      end
      a_d3 <= a_d2[3];
      b_d3 <= b_d2[3];
    end
  end

  assign {awe3, awe2, awe1, awe0} = vld_q;
  assign {bwe3, bwe2, bwe1, bwe0} = vld_q;

  assign a_in0 = vld_q[0] ? bus.buf_a_rdata[DW-1:0] : '0;
  assign a_in1 = vld_q[1] ? a_d1[1] : '0;
  assign a_in2 = vld_q[2] ? a_d2[2] : '0;
  assign a_in3 = vld_q[3] ? a_d3    : '0;
  assign b_in0 = vld_q[0] ? bus.buf_b_rdata[DW-1:0] : '0;
  assign b_in1 = vld_q[1] ? b_d1[1] : '0;
  assign b_in2 = vld_q[2] ? b_d2[2] : '0;
  assign b_in3 = vld_q[3] ? b_d3    : '0;

endmodule

// File: tb/tb_systolic_seq.sv
// Directed bench for systolic_seq: cycle-by-cycle expected edge traffic from a
// timing model relative to the CLR cycle, plus error/abort/reset scenarios.
module tb_systolic_seq;
  localparam int DW = 16;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start;
  logic [LW-1:0] max_cntr;
  logic [DW-1:0] a_in0, a_in1, a_in2, a_in3, b_in0, b_in1, b_in2, b_in3;
  logic awe0, awe1, awe2, awe3, bwe0, bwe1, bwe2, bwe3;

  int n_vec = 0;
  int n_err = 0;

  systolic_seq_if #(.DW(DW), .LW(LW)) bus ();

  systolic_seq #(.DW(DW), .LW(LW), .DRAIN_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .start(start), .max_cntr(max_cntr),
    .a_in0(a_in0), .a_in1(a_in1), .a_in2(a_in2), .a_in3(a_in3),
    .b_in0(b_in0), .b_in1(b_in1), .b_in2(b_in2), .b_in3(b_in3),
    .awe0(awe0), .awe1(awe1), .awe2(awe2), .awe3(awe3),
    .bwe0(bwe0), .bwe1(bwe1), .bwe2(bwe2), .bwe3(bwe3)
  );

  always #5 clk = ~clk;

  // Operand buffer: one-cycle read latency, lane i of A = {i, k}, of B = {0x10+i, k}.
  always @(posedge clk) begin
    if (bus.buf_ren) begin
      for (int i = 0; i < 4; i++) begin
        bus.buf_a_rdata[i*DW +: DW] <= {8'(i), bus.buf_radr};
        bus.buf_b_rdata[i*DW +: DW] <= {8'(8'h10 + i), bus.buf_radr};
      end
    end
  end

  wire [3:0]  awe   = {awe3, awe2, awe1, awe0};
  wire [3:0]  bwe   = {bwe3, bwe2, bwe1, bwe0};
  wire [63:0] a_all = {a_in3, a_in2, a_in1, a_in0};
  wire [63:0] b_all = {b_in3, b_in2, b_in1, b_in0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_busy"},  bus.busy, 0);
    check({pfx, "_start"}, start, 0);
    check({pfx, "_done"},  bus.done, 0);
    check({pfx, "_ren"},   bus.buf_ren, 0);
    check({pfx, "_awe"},   awe, 0);
    check({pfx, "_bwe"},   bwe, 0);
    check({pfx, "_a_in"},  a_all, 0);
    check({pfx, "_b_in"},  b_all, 0);
  endtask

  // Issue go (optionally with a simultaneous abort), then compare every cycle
  // from CLR (t=0) to two cycles past the expected done pulse.
  task automatic run(input int len, input int abort_t, input int go_t, input bit abort_with_go);
    bus.cfg_len   = 8'(len);
    bus.cfg_go    = 1'b1;
    bus.cfg_abort = abort_with_go;
    @(negedge clk);
    for (int t = 0; t <= len + 15; t++) begin
      int c;
      bit killed, feed;
      logic [3:0]  e_we;
      logic [63:0] e_a, e_b;
      bus.cfg_go    = 1'b0;
      bus.cfg_abort = 1'b0;
      bus.cfg_len   = 8'd77;
      killed = (abort_t >= 0) && (t > abort_t);
      c      = t - 1;
      feed   = !killed && (t >= 1) && (t <= len + 4);
      e_we = '0; e_a = '0; e_b = '0;
      for (int i = 0; i < 4; i++) begin
        if (feed && c >= i + 1 && c <= len + i) begin
          e_we[i] = 1'b1;
          e_a[i*16 +: 16] = {8'(i), 8'(c - 1 - i)};
          e_b[i*16 +: 16] = {8'(8'h10 + i), 8'(c - 1 - i)};
        end
      end
      check("busy",  bus.busy,  !killed && t <= len + 13);
      check("start", start,     !killed && t == 0);
      check("done",  bus.done,  !killed && t == len + 13);
      check("ren",   bus.buf_ren, feed && c < len);
      check("radr",  bus.buf_radr, (feed && c < len) ? 64'(c) : 64'd0);
      check("awe",   awe, e_we);
      check("bwe",   bwe, e_we);
      check("a_in",  a_all, e_a);
      check("b_in",  b_all, e_b);
      if (t == 0) begin
        check("err_len_clr", bus.err_len, 0);
        check("max_cntr",    max_cntr, 64'(len));
        if (abort_t < 0) check("aborted_clr", bus.aborted, 0);
      end
      if (killed && t == abort_t + 1) check("aborted_set", bus.aborted, 1);
      if (t == abort_t) bus.cfg_abort = 1'b1;
      if (t == go_t) begin
        bus.cfg_go  = 1'b1;
        bus.cfg_len = 8'd9;
      end
      @(negedge clk);
    end
    bus.cfg_go    = 1'b0;
    bus.cfg_abort = 1'b0;
  endtask

  initial begin
    bus.cfg_go      = 1'b0;
    bus.cfg_abort   = 1'b0;
    bus.cfg_len     = '0;
    bus.buf_a_rdata = '0;
    bus.buf_b_rdata = '0;
    repeat (2) @(negedge clk);
    check_quiet("rst");
    check("rst_max_cntr", max_cntr, 0);
    check("rst_err_len",  bus.err_len, 0);
    check("rst_aborted",  bus.aborted, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic run, K=4.
    run(4, -1, -1, 1'b0);
    check("max_hold4", max_cntr, 4);

    // Abort while idle does nothing.
    bus.cfg_abort = 1'b1;
    @(negedge clk);
    bus.cfg_abort = 1'b0;
    @(negedge clk);
    check("idle_abort_busy", bus.busy, 0);
    check("idle_abort_flag", bus.aborted, 0);

    // Zero length is rejected.
    bus.cfg_len = 8'd0;
    bus.cfg_go  = 1'b1;
    @(negedge clk);
    bus.cfg_go = 1'b0;
    check("len0_err",   bus.err_len, 1);
    check("len0_max",   max_cntr, 4);
    check_quiet("len0");
    @(negedge clk);
    check("len0_busy2", bus.busy, 0);

    // Single-element run clears err_len.
    run(1, -1, -1, 1'b0);

    // Maximum length: reads k=0..254 only.
    run(255, -1, -1, 1'b0);
    check("max_hold255", max_cntr, 255);

    // Abort on FEED cycle 3 of K=10 (t = 1 + 3).
    run(10, 4, -1, 1'b0);
    repeat (3) @(negedge clk);
    check("post_abort_done", bus.done, 0);
    check("post_abort_flag", bus.aborted, 1);

    // Go and abort together while idle: go wins and the run clears aborted.
    run(3, -1, -1, 1'b1);

    // Go during DRAIN (t = len + 7) is ignored.
    run(4, -1, 11, 1'b0);
    check("drain_go_max", max_cntr, 4);
    check("drain_go_err", bus.err_len, 0);

    // Asynchronous reset in the middle of FEED.
    bus.cfg_len = 8'd10;
    bus.cfg_go  = 1'b1;
    @(negedge clk);
    bus.cfg_go = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_awe0", awe0, 1);
    #2 rst_n = 1'b0;
    #1;
    check_quiet("midrst");
    check("midrst_max", max_cntr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle", bus.busy, 0);
    run(2, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/systolic_seq.md
Name: systolic_seq

Overview:
- Sequencer for the 4x4 systolic PE array.
- On a go command it:
  - latches the inner-product length;
  - pulses the array clear/start;
  - streams A-row and B-column operands from the operand buffer into the four west and four north array edges with the diagonal skew the array needs;
  - waits a fixed drain time, then signals done.
- Sits between the io register block (config/status) and the operand buffer RAM on one side, and the array edge ports on the other.

Parameters:
- DW, 16, operand width per lane
- LW, 8, length/counter width (max_cntr width)
- DRAIN_CYC, 8, cycles from last edge write to done (array flush + accumulate)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_go  in  1  single-cycle run request
- cfg_abort  in  1  single-cycle abort request
- cfg_len  in  LW  inner-product length K, valid 1..255
- busy  out  1  run in progress
- done  out  1  single-cycle completion pulse
- err_len  out  1  sticky: go issued with cfg_len==0
- aborted  out  1  sticky: last run was aborted
- buf_ren  out  1  operand buffer read enable
- buf_radr  out  LW  operand buffer index k
- buf_a_rdata  in  4*DW  A column k, lane i in bits [16i+15:16i]
- buf_b_rdata  in  4*DW  B row k, same packing
- start  out  1  array clear/start pulse
- max_cntr  out  LW  length to array
- a_in0..a_in3  out  DW each  west-edge operands
- b_in0..b_in3  out  DW each  north-edge operands
- awe0..awe3  out  1 each  west-edge write strobes
- bwe0..bwe3  out  1 each  north-edge write strobes

Behaviour:
- Reset values: all outputs 0, FSM IDLE, counters 0, skew pipelines cleared.
- FSM states: IDLE, CLR, FEED, DRAIN, DONE.
- IDLE
  - cfg_go with cfg_len!=0: latch cfg_len into max_cntr; clear err_len and aborted; go to CLR.
  - cfg_go with cfg_len==0: set err_len, stay in IDLE.
- CLR: start=1 for exactly this one cycle; busy=1; next state FEED.
- FEED
  - Read counter k=0..len-1: buf_ren=1 and buf_radr=k on cycles 0..len-1 of FEED.
  - Read data arrives one cycle after buf_ren.
  - Lane i (0..3) is delayed by i further registers.
  - awe_i/bwe_i=1 exactly when lane i holds valid data; a_in_i/b_in_i carry that data.
  - When a lane's strobe is 0, its data outputs are 0.
  - FEED lasts len+4 cycles: the last lane-3 strobe occurs on FEED cycle len+3, then the FSM goes to DRAIN.
- DRAIN: count DRAIN_CYC cycles, strobes all 0, then go to DONE.
- DONE: done=1 for one cycle, busy still 1; next state IDLE with busy=0.
- busy=1 in CLR, FEED, DRAIN and DONE.
- max_cntr holds the latched value until the next accepted go.
- cfg_go while busy is ignored: no latch, no error.
- cfg_abort while busy, from any non-IDLE state:
  - next cycle enter IDLE;
  - clear the skew pipeline, buf_ren and all strobes;
  - set aborted;
  - no done pulse.
- cfg_abort in IDLE: no effect.
- Same cycle cfg_go and cfg_abort in IDLE: go wins.
- Same cycle cfg_go and cfg_abort while busy: abort wins, go is dropped.
- Counters must not wrap: len=255 reads k=0..254 only.
- Reset mid-run: immediate return to reset values; no done pulse.

Test Plan:
- Reset, then cfg_len=4, cfg_go
  - -> start high 1 cycle; buf_radr 0,1,2,3 on consecutive cycles.
  - -> awe0 high 4 cycles starting 1 cycle after first ren; awe3 starts 3 cycles after awe0.
  - -> done exactly 1+8+8 cycles after CLR (len+4 FEED, DRAIN_CYC=8), busy low the cycle after.
- Buffer returns lane i = 16'h0i0k
  - -> a_in2 sequence 0x0200..0x0203, aligned with awe2; b_in lanes match bwe strobes.
- cfg_len=0 with cfg_go -> err_len=1, busy stays 0, no start.
- Next go with cfg_len=1 -> err_len clears, single strobe per lane, done after 1+5+8 cycles.
- cfg_len=255 -> exactly 255 reads, last buf_radr=254, max_cntr=255, no wrap.
- Abort on FEED cycle 3 of len=10
  - -> busy low next cycle; all strobes 0; aborted=1; no done.
  - -> a following cfg_go runs normally and clears aborted.
- cfg_go pulsed during DRAIN -> ignored; max_cntr unchanged; exactly one done pulse.
- rst_n asserted mid-FEED -> all outputs 0 asynchronously; FSM restarts from IDLE.
